// File: rtl/bnn_pe_array_4x4.sv
// -----------------------------------------------------------------------------
// bnn_pe_array_4x4
//   4x4 weight-stationary binary-neural-network PE array (XNOR-popcount MAC).
//   Activations ripple down each column through one register per PE; every
//   row adds its four PE contributions to psum_row_r_in combinationally and
//   registers the total once at the right-hand edge of the row.
//
// Optional build macro:
//   PE_ARRAY_PSUM_SAT_EN  defined   -> row sum saturates at 2^PSUM_W-1
//                         undefined -> row sum wraps modulo 2^PSUM_W (default)
//
// Ports:
//   clk_in                        rising-edge clock
//   rst_in                        asynchronous active-low reset
//   load_weight_in / weight_in    serial row-major weight load, one PE/cycle
//   activation_column_{0..3}_in   activation entering the top of column c
//   psum_row_{0..3}_in            partial sum entering the left of row r
//   psum_row_{0..3}_out           registered partial sum leaving row r
//   activation_column_{0..3}_out  activation leaving the bottom of column c
// -----------------------------------------------------------------------------

// Single processing element: holds one weight and one activation register,
// and produces the XNOR-popcount of its incoming activation against the weight.
module bnn_pe #(
    parameter int DATA_W = 9,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] act_in,
    input  logic              w_we,
    input  logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] act_q,
    output logic [CNT_W-1:0]  contrib
);
    logic [DATA_W-1:0] w_q;
    logic [DATA_W-1:0] match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q   <= '0;
            act_q <= '0;
        end else begin
            act_q <= act_in;
            if (w_we) w_q <= w_data;
        end
    end

    // Contribution uses the activation arriving at this PE this cycle, not the
    // one it is about to register.
    always_comb begin
        match   = ~(act_in ^ w_q);
        contrib = '0;
        for (int i = 0; i < DATA_W; i++)
            contrib = contrib + CNT_W'(match[i]);
    end
endmodule

module bnn_pe_array_4x4 #(
    parameter int DATA_W = 9,
    parameter int PSUM_W = 13
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              load_weight_in,
    input  logic [DATA_W-1:0] weight_in,
    input  logic [DATA_W-1:0] activation_column_0_in,
    input  logic [DATA_W-1:0] activation_column_1_in,
    input  logic [DATA_W-1:0] activation_column_2_in,
    input  logic [DATA_W-1:0] activation_column_3_in,
    input  logic [PSUM_W-1:0] psum_row_0_in,
    input  logic [PSUM_W-1:0] psum_row_1_in,
    input  logic [PSUM_W-1:0] psum_row_2_in,
    input  logic [PSUM_W-1:0] psum_row_3_in,
    output logic [PSUM_W-1:0] psum_row_0_out,
    output logic [PSUM_W-1:0] psum_row_1_out,
    output logic [PSUM_W-1:0] psum_row_2_out,
    output logic [PSUM_W-1:0] psum_row_3_out,
    output logic [DATA_W-1:0] activation_column_0_out,
    output logic [DATA_W-1:0] activation_column_1_out,
    output logic [DATA_W-1:0] activation_column_2_out,
    output logic [DATA_W-1:0] activation_column_3_out
);
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int K_W   = $clog2(ROWS * COLS);
    // One spare bit is enough: max sum is (2^PSUM_W-1) + ROWS*DATA_W.
    localparam int SUM_W = PSUM_W + 1;

    logic [COLS-1:0][DATA_W-1:0]                act_col;
    logic [ROWS-1:0][PSUM_W-1:0]                psum_in;
    logic [ROWS-1:0][PSUM_W-1:0]                psum_d;
    logic [ROWS-1:0][PSUM_W-1:0]                psum_q;
    logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]      pe_act_in;
    logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]      pe_act_q;
    logic [ROWS-1:0][COLS-1:0][CNT_W-1:0]       pe_contrib;
    logic [K_W-1:0]                             load_cnt;

    assign act_col = {activation_column_3_in, activation_column_2_in,
                      activation_column_1_in, activation_column_0_in};
    assign psum_in = {psum_row_3_in, psum_row_2_in, psum_row_1_in, psum_row_0_in};

    // Load index wraps naturally at 15->0; any idle cycle rewinds to PE(0,0).
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)             load_cnt <= '0;
        else if (load_weight_in) load_cnt <= load_cnt + 1'b1;
        else                     load_cnt <= '0;
    end

    function automatic logic [SUM_W-1:0] row_total(
        input logic [PSUM_W-1:0]            base,
        input logic [COLS-1:0][CNT_W-1:0]   c
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(base);
        for (int i = 0; i < COLS; i++)
            s = s + SUM_W'(c[i]);
        return s;
    endfunction

    genvar r, c;
    generate
        for (r = 0; r < ROWS; r++) begin : g_row
            logic [SUM_W-1:0] row_sum;

            for (c = 0; c < COLS; c++) begin : g_col
                if (r == 0) begin : g_top
                    assign pe_act_in[r][c] = act_col[c];
                end else begin : g_below
                    assign pe_act_in[r][c] = pe_act_q[r-1][c];
                end

                bnn_pe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_pe (
                    .clk     (clk_in),
                    .rst_n   (rst_in),
                    .act_in  (pe_act_in[r][c]),
                    .w_we    (load_weight_in && (load_cnt == K_W'(r * COLS + c))),
                    .w_data  (weight_in),
                    .act_q   (pe_act_q[r][c]),
                    .contrib (pe_contrib[r][c])
                );
            end

            assign row_sum = row_total(psum_in[r], pe_contrib[r]);
`ifdef PE_ARRAY_PSUM_SAT_EN
            assign psum_d[r] = row_sum[PSUM_W] ? {PSUM_W{1'b1}} : row_sum[PSUM_W-1:0];
`else
            assign psum_d[r] = row_sum[PSUM_W-1:0];
`endif
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) psum_q <= '0;
        else         psum_q <= psum_d;
    end

    assign psum_row_0_out = psum_q[0];
    assign psum_row_1_out = psum_q[1];
    assign psum_row_2_out = psum_q[2];
    assign psum_row_3_out = psum_q[3];

    assign activation_column_0_out = pe_act_q[ROWS-1][0];
    assign activation_column_1_out = pe_act_q[ROWS-1][1];
    assign activation_column_2_out = pe_act_q[ROWS-1][2];
    assign activation_column_3_out = pe_act_q[ROWS-1][3];
endmodule

// File: tb/tb_bnn_pe_array_4x4.sv
module tb_bnn_pe_array_4x4;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_weight;
    logic [8:0]  weight;
    logic [8:0]  act_i [4];
    logic [12:0] psum_i [4];
    logic [12:0] psum_o [4];
    logic [8:0]  act_o [4];

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bnn_pe_array_4x4 dut (
        .clk_in                  (clk),
        .rst_in                  (rst_n),
        .load_weight_in          (load_weight),
        .weight_in               (weight),
        .activation_column_0_in  (act_i[0]),
        .activation_column_1_in  (act_i[1]),
        .activation_column_2_in  (act_i[2]),
        .activation_column_3_in  (act_i[3]),
        .psum_row_0_in           (psum_i[0]),
        .psum_row_1_in           (psum_i[1]),
        .psum_row_2_in           (psum_i[2]),
        .psum_row_3_in           (psum_i[3]),
        .psum_row_0_out          (psum_o[0]),
        .psum_row_1_out          (psum_o[1]),
        .psum_row_2_out          (psum_o[2]),
        .psum_row_3_out          (psum_o[3]),
        .activation_column_0_out (act_o[0]),
        .activation_column_1_out (act_o[1]),
        .activation_column_2_out (act_o[2]),
        .activation_column_3_out (act_o[3])
    );

    typedef struct {
        logic [15:0][8:0] w;      // row-major load order
        logic [3:0][8:0]  act;    // per column
        logic [3:0][12:0] psum;   // per row
        logic [3:0][12:0] exp;    // expected psum_row_r_out
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with load deasserted.
    task automatic load_weights(input logic [15:0][8:0] w);
        for (int i = 0; i < 16; i++) begin
            load_weight = 1'b1;
            weight      = w[i];
            @(negedge clk);
        end
        load_weight = 1'b0;
        weight      = '0;
    endtask

    task automatic apply_vec(input int v);
        load_weights(vecs[v].w);
        for (int i = 0; i < 4; i++) begin
            act_i[i]  = vecs[v].act[i];
            psum_i[i] = vecs[v].psum[i];
        end
        repeat (5) @(negedge clk);
        for (int r = 0; r < 4; r++)
            check($sformatf("vec%0d_row%0d", v, r), 32'(psum_o[r]), 32'(vecs[v].exp[r]));
    endtask

    initial begin
        // 0: all-zero weights and activations -> 4 x 9 per row
        vecs[0].w = '0; vecs[0].act = '0; vecs[0].psum = '0;
        for (int r = 0; r < 4; r++) vecs[0].exp[r] = 13'd36;

        // 1: only w(1,1) = 1FF -> row 1 loses 9
        vecs[1].w = '0; vecs[1].w[5] = 9'h1FF; vecs[1].act = '0; vecs[1].psum = '0;
        vecs[1].exp[0] = 13'd36; vecs[1].exp[1] = 13'd27;
        vecs[1].exp[2] = 13'd36; vecs[1].exp[3] = 13'd36;

        // 2: all weights 1FF -> contribution = popcount(act) = 0+9+4+4
        for (int i = 0; i < 16; i++) vecs[2].w[i] = 9'h1FF;
        vecs[2].act[0] = 9'h000; vecs[2].act[1] = 9'h1FF;
        vecs[2].act[2] = 9'h0F0; vecs[2].act[3] = 9'h00F;
        for (int r = 0; r < 4; r++) begin
            vecs[2].psum[r] = 13'd100;
            vecs[2].exp[r]  = 13'd117;
        end

        // 3: row 0 overflow, 8190 + 36
        vecs[3].w = '0; vecs[3].act = '0; vecs[3].psum = '0;
        vecs[3].psum[0] = 13'd8190;
`ifdef PE_ARRAY_PSUM_SAT_EN
        vecs[3].exp[0] = 13'd8191;
`else
        vecs[3].exp[0] = 13'd34;
`endif
        for (int r = 1; r < 4; r++) vecs[3].exp[r] = 13'd36;

        // 4: mixed weights per row, mixed activations per column, each row = psum + 18
        for (int c = 0; c < 4; c++) begin
            vecs[4].w[c]      = 9'h000;
            vecs[4].w[4 + c]  = 9'h1FF;
            vecs[4].w[8 + c]  = 9'h155;
            vecs[4].w[12 + c] = 9'h0AA;
        end
        vecs[4].act[0] = 9'h155; vecs[4].act[1] = 9'h0AA;
        vecs[4].act[2] = 9'h1FF; vecs[4].act[3] = 9'h000;
        vecs[4].psum[0] = 13'd1000; vecs[4].psum[1] = 13'd2000;
        vecs[4].psum[2] = 13'd3000; vecs[4].psum[3] = 13'd4000;
        vecs[4].exp[0]  = 13'd1018; vecs[4].exp[1]  = 13'd2018;
        vecs[4].exp[2]  = 13'd3018; vecs[4].exp[3]  = 13'd4018;

        rst_n = 1'b0; load_weight = 1'b0; weight = '0;
        for (int i = 0; i < 4; i++) begin act_i[i] = '0; psum_i[i] = '0; end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_psum%0d", i), 32'(psum_o[i]), 32'd0);
            check($sformatf("reset_act%0d", i), 32'(act_o[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) apply_vec(v);

        // psum_row_2_in step 0 -> 50 with everything else held
        apply_vec(0);
        psum_i[2] = 13'd50;
        #1;
        check("step_row2_before_edge", 32'(psum_o[2]), 32'd36);
        @(negedge clk);
        check("step_row2_after_edge", 32'(psum_o[2]), 32'd86);
        for (int r = 0; r < 4; r++)
            if (r != 2) check($sformatf("step_row%0d_held", r), 32'(psum_o[r]), 32'd36);
        psum_i[2] = '0;

        // Staggered activations appear at the column outputs 4 cycles later
        begin
            logic [8:0] hist [12][4];
            for (int i = 0; i < 12; i++) begin
                if (i >= 4)
                    for (int c = 0; c < 4; c++)
                        check($sformatf("act_delay_t%0d_c%0d", i, c), 32'(act_o[c]), 32'(hist[i-4][c]));
                for (int c = 0; c < 4; c++) begin
                    hist[i][c] = 9'((i * 37 + c * 101 + 5) & 9'h1FF);
                    act_i[c]   = hist[i][c];
                end
                @(negedge clk);
            end
        end

        // Reset in the middle of a weight load
        for (int i = 0; i < 4; i++) begin act_i[i] = 9'h0F0 + 9'(i); psum_i[i] = 13'd100; end
        for (int i = 0; i < 7; i++) begin
            load_weight = 1'b1;
            weight      = 9'h1FF;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("midrst_psum%0d", i), 32'(psum_o[i]), 32'd0);
            check($sformatf("midrst_act%0d", i), 32'(act_o[i]), 32'd0);
        end
        @(negedge clk);
        check("midrst_hold_psum0", 32'(psum_o[0]), 32'd0);
        load_weight = 1'b0; weight = '0;
        for (int i = 0; i < 4; i++) begin act_i[i] = '0; psum_i[i] = '0; end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Counter must restart at PE(0,0): w(1,1) marker lands in row 1 only
        apply_vec(1);
        apply_vec(0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/bnn_pe_array_4x4.md
Name: bnn_pe_array_4x4

Overview:
- 4x4 binary-neural-network processing-element array, weight-stationary, in matrix-multiplication form.
- Each PE holds a 9-bit binary weight vector. It computes XNOR-popcount against the 9-bit activation passing through it.
- Activations flow down columns through per-PE registers. Partial sums flow left-to-right across each row and are registered once at the row output.
- Sits between the activation/weight buffers and the accumulator stage.

Parameters:
- DATA_W, 9, width of activations, weights and the XNOR/popcount vector.
- PSUM_W, 13, partial-sum width; all psum arithmetic is modulo 2^PSUM_W.

Ports:
- clk_in  input  1  single clock; all state updates on its rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- load_weight_in  input  1  high: weight_in is written into the next PE each cycle.
- weight_in  input  DATA_W  weight word being loaded.
- activation_column_{0..3}_in  input  DATA_W  activation entering the top of column c.
- psum_row_{0..3}_in  input  PSUM_W  partial sum entering the left of row r.
- psum_row_{0..3}_out  output  PSUM_W  registered partial sum leaving the right of row r.
- activation_column_{0..3}_out  output  DATA_W  activation leaving the bottom of column c (row-3 register).

Behaviour:
- Reset (rst_in=0, asynchronous) clears the following to 0 immediately, including mid-load or mid-compute:
  - all 16 weight registers;
  - all 16 activation registers;
  - all 4 psum output registers;
  - the weight-load counter.
- Weight load:
  - A 4-bit counter k starts at 0.
  - On each rising edge with load_weight_in=1, weight_in is written to PE(row=k/4, col=k%4), then k increments, wrapping 15->0.
  - On a rising edge with load_weight_in=0, k returns to 0 and weights hold.
  - Sixteen consecutive load cycles therefore fill the array in row-major order.
  - Loading and computing may overlap; a PE uses its new weight from the cycle after the write.
- Activation path:
  - PE(0,c) uses activation_column_c_in directly.
  - PE(r,c) for r>0 uses the activation register of PE(r-1,c).
  - Every PE registers its input activation each cycle.
  - So activation_column_c_out is activation_column_c_in delayed 4 cycles, and row r sees a value delayed r cycles.
- PE contribution: contrib(r,c) = popcount(~(act(r,c) ^ w(r,c))), range 0..9, unsigned.
- Row sum:
  - Combinational across the row: psum_row_r_in + contrib(r,0)+contrib(r,1)+contrib(r,2)+contrib(r,3).
  - Truncated to PSUM_W bits (wrap-around).
  - Registered into psum_row_r_out: 1-cycle latency from psum_row_r_in.
- Steady-state result requires activation column inputs held for at least r+1 cycles before psum_row_r_out is sampled.
- No handshake and no stall; the array computes every cycle.
- X/undefined psum inputs propagate; no masking is applied.

Optional Feature:
- Macro PE_ARRAY_PSUM_SAT_EN.
- Defined: the row sum saturates at 2^PSUM_W-1 (8191) instead of wrapping.
- Undefined (default): modulo-2^PSUM_W wrap.

Test Plan:
1. Load all 16 weights = 0, hold all activations = 0, psum_in = 0 -> after settling, every psum_row_r_out = 36 (4 PEs x 9).
2. Load weights row-major with w(1,1)=9'h1FF (load index 5) and all others 0; activations all 0; psum_in = 0 -> rows 0, 2, 3 = 36; row 1 = 27.
3. Load weights = 9'h1FF; activations column c = 9'h000, 9'h1FF, 9'h0F0, 9'h00F; psum_in = 100 -> each row = 100 + 0 + 9 + 4 + 4 = 117. Also drive staggered activations and check that activation_column_c_out reproduces them 4 cycles later.
4. psum_row_0_in = 8190 with contributions totalling 36 -> out = 34 by default; out = 8191 with PE_ARRAY_PSUM_SAT_EN.
5. Assert rst_in low mid-weight-load (after 7 words) -> all outputs read 0 immediately; after release, a fresh 16-word load starts at PE(0,0) and case 1 reproduces 36.
6. Change psum_row_2_in from 0 to 50 with activations and weights held -> psum_row_2_out increases by exactly 50 one cycle later; other rows unchanged.
